// File: rtl/bridge_gate_sequencer.sv
// H-bridge gate sequencer: idle/precharge/run start-up, shoot-through block,
// and sticky over-current/over-voltage fault latch on the tank ADC samples.

module bgs_ovr_chan #(
  parameter logic [13:0] LIMIT     = 14'd6000,
  parameter int          OVR_COUNT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [13:0] smp,
  output logic        trip
);
  logic [14:0] mag;
  logic        over;
  logic [7:0]  cnt;

  // 15-bit magnitude so -8192 maps to 8192 instead of wrapping
  assign mag  = smp[13] ? (15'd0 - {smp[13], smp}) : {1'b0, smp};
  assign over = mag > {1'b0, LIMIT};
  assign trip = run & over & (cnt >= 8'(OVR_COUNT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (!run || !over) cnt <= '0;
    else if (cnt != 8'hff)  cnt <= cnt + 1'b1;
  end
endmodule

module bridge_gate_sequencer #(
  parameter int          PRECHARGE_CYCLES  = 1000,
  parameter logic [13:0] I_LIMIT           = 14'd6000,
  parameter logic [13:0] V_LIMIT           = 14'd7000,
  parameter int          OVR_COUNT         = 4,
  parameter int          FAULT_HOLD_CYCLES = 100000
) (
  input  logic               i_clock,
  input  logic               i_RESET,
  input  logic               i_enable,
  input  logic [3:0]         i_MOSFET,
  input  logic signed [13:0] i_vC,
  input  logic signed [13:0] i_iC,
  input  logic               i_fault_clear,
  output logic [3:0]         o_Q,
  output logic               o_on,
  output logic [1:0]         o_state,
  output logic [2:0]         o_fault_code
);
  localparam int PW = $clog2(PRECHARGE_CYCLES + 1);
  localparam int HW = $clog2(FAULT_HOLD_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE = 2'b00, S_PRE = 2'b01, S_RUN = 2'b10, S_FAULT = 2'b11} state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   pre_cnt, pre_nx;
  logic [HW-1:0]   hold_cnt, hold_nx;
  logic [2:0]      code_nx;
  logic [3:0]      q_nx;
  logic [1:0]      rst_pipe;
  logic            rst;
  logic            shoot;
  logic [1:0]      trip;
  logic [1:0][13:0] smp;

  // async assert, release aligned to the clock
  always_ff @(posedge i_clock or posedge i_RESET) begin
    if (i_RESET) rst_pipe <= 2'b11;
    else         rst_pipe <= {rst_pipe[0], 1'b0};
  end
  assign rst = rst_pipe[1];

  assign smp   = {i_vC, i_iC};
  assign shoot = (i_MOSFET[0] & i_MOSFET[2]) | (i_MOSFET[1] & i_MOSFET[3]);

  // channel 0 = current (code bit1), channel 1 = voltage (code bit2)
  for (genvar g = 0; g < 2; g++) begin : g_chan
    bgs_ovr_chan #(
      .LIMIT    (g == 0 ? I_LIMIT : V_LIMIT),
      .OVR_COUNT(OVR_COUNT)
    ) u_chan (
      .clk (i_clock),
      .rst (rst),
      .run (state == S_RUN),
      .smp (smp[g]),
      .trip(trip[g])
    );
  end

  always_comb begin
    state_nx = state;
    pre_nx   = pre_cnt;
    hold_nx  = hold_cnt;
    code_nx  = o_fault_code;
    case (state)
      S_IDLE: begin
        pre_nx  = '0;
        hold_nx = '0;
        if (i_enable) state_nx = S_PRE;
      end
      S_PRE: begin
        if (!i_enable) begin
          state_nx = S_IDLE;
          pre_nx   = '0;
        end else if (pre_cnt == PW'(PRECHARGE_CYCLES - 1)) begin
          state_nx = S_RUN;
        end else begin
          pre_nx = pre_cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (shoot || (|trip)) begin
          state_nx = S_FAULT;
          code_nx  = o_fault_code | {trip[1], trip[0], shoot};
          hold_nx  = '0;
        end else if (!i_enable) begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        if (hold_cnt == HW'(FAULT_HOLD_CYCLES) && i_fault_clear && !i_enable) begin
          state_nx = S_IDLE;
          code_nx  = '0;
          hold_nx  = '0;
        end else if (hold_cnt != HW'(FAULT_HOLD_CYCLES)) begin
          hold_nx = hold_cnt + 1'b1;
        end
      end
    endcase

    // shoot is also masked on the PRECHARGE->RUN edge, so o_Q is never illegal
    case (state_nx)
      S_PRE:   q_nx = 4'b1100;
      S_RUN:   q_nx = shoot ? 4'b0000 : i_MOSFET;
      default: q_nx = 4'b0000;
    endcase
  end

  always_ff @(posedge i_clock or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      pre_cnt      <= '0;
      hold_cnt     <= '0;
      o_fault_code <= '0;
      o_Q          <= '0;
      o_on         <= 1'b0;
    end else begin
      state        <= state_nx;
      pre_cnt      <= pre_nx;
      hold_cnt     <= hold_nx;
      o_fault_code <= code_nx;
      o_Q          <= q_nx;
      o_on         <= (state_nx == S_RUN);
    end
  end

  assign o_state = state;
endmodule

// File: tb/tb_bridge_gate_sequencer.sv
// Scoreboard bench: stimulus queues cycle-tagged expectations, a negedge
// monitor pops and compares them and watches the gate-pair invariant.

module tb_bridge_gate_sequencer;
  localparam int FH = 2000;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               en = 1'b0;
  logic [3:0]         mos = 4'b0000;
  logic signed [13:0] vC = '0;
  logic signed [13:0] iC = '0;
  logic               clr = 1'b0;
  logic [3:0]         q;
  logic               on;
  logic [1:0]         st;
  logic [2:0]         code;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int         cyc;
    string      nm;
    logic [1:0] st;
    logic [3:0] q;
    logic       on;
    logic [2:0] code;
  } exp_t;
  exp_t sbq[$];
  exp_t e;

  bridge_gate_sequencer #(.FAULT_HOLD_CYCLES(FH)) dut (
    .i_clock      (clk),
    .i_RESET      (rst),
    .i_enable     (en),
    .i_MOSFET     (mos),
    .i_vC         (vC),
    .i_iC         (iC),
    .i_fault_clear(clr),
    .o_Q          (q),
    .o_on         (on),
    .o_state      (st),
    .o_fault_code (code)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    checks++;
    if ((q[0] & q[2]) | (q[1] & q[3])) begin
      failures++;
      $display("FAIL invariant cyc=%0d o_Q=%b", cyc, q);
    end
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      checks++;
      if (e.cyc != cyc || st !== e.st || q !== e.q || on !== e.on || code !== e.code) begin
        failures++;
        $display("FAIL %s cyc=%0d (due %0d) got st=%b q=%b on=%b code=%b want st=%b q=%b on=%b code=%b",
                 e.nm, cyc, e.cyc, st, q, on, code, e.st, e.q, e.on, e.code);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic expect_at(input int dly, input string nm, input logic [1:0] s,
                           input logic [3:0] qq, input logic o, input logic [2:0] c);
    exp_t x;
    x.cyc = cyc + dly; x.nm = nm; x.st = s; x.q = qq; x.on = o; x.code = c;
    sbq.push_back(x);
  endtask

  // from IDLE: exactly 1000 cycles of 1100, then pass-through of mos
  task automatic start_run(input logic [3:0] m);
    en = 1'b1; mos = m;
    expect_at(0,    "pre_idle",  2'b00, 4'b0000, 1'b0, 3'b000);
    expect_at(1,    "pre_enter", 2'b01, 4'b1100, 1'b0, 3'b000);
    expect_at(1000, "pre_last",  2'b01, 4'b1100, 1'b0, 3'b000);
    expect_at(1001, "run_enter", 2'b10, m,       1'b1, 3'b000);
    repeat (1001) tick();
  endtask

  task automatic clear_fault();
    en = 1'b0;
    repeat (FH + 5) tick();
    clr = 1'b1;
    expect_at(1, "clear_exit", 2'b00, 4'b0000, 1'b0, 3'b000);
    tick();
    clr = 1'b0;
    tick();
  endtask

  int b;

  initial begin
    #1 rst = 1'b1;
    repeat (3) tick();
    expect_at(0, "reset", 2'b00, 4'b0000, 1'b0, 3'b000);
    tick();
    rst = 1'b0;
    repeat (5) tick();
    expect_at(0, "idle_after_rst", 2'b00, 4'b0000, 1'b0, 3'b000);
    tick();

    // start-up and pass-through
    start_run(4'b0001);
    mos = 4'b1000;
    expect_at(1, "pass_1000", 2'b10, 4'b1000, 1'b1, 3'b000);
    tick();
    mos = 4'b0110;
    expect_at(1, "pass_0110", 2'b10, 4'b0110, 1'b1, 3'b000);
    repeat (2) tick();
    en = 1'b0;
    expect_at(1, "run_drop", 2'b00, 4'b0000, 1'b0, 3'b000);
    repeat (2) tick();

    // enable drop mid-precharge, then a full precharge again
    b = cyc;
    en = 1'b1;
    expect_at(1, "pre2_enter", 2'b01, 4'b1100, 1'b0, 3'b000);
    wait_until(b + 500);
    en = 1'b0;
    expect_at(0, "pre_500", 2'b01, 4'b1100, 1'b0, 3'b000);
    expect_at(1, "pre_drop", 2'b00, 4'b0000, 1'b0, 3'b000);
    repeat (3) tick();
    start_run(4'b0001);

    // shoot-through and fault-clear rules
    b = cyc;
    mos = 4'b0101;
    expect_at(0, "pre_shoot", 2'b10, 4'b0001, 1'b1, 3'b000);
    expect_at(1, "shoot", 2'b11, 4'b0000, 1'b0, 3'b001);
    tick();
    mos = 4'b0001;
    repeat (2) tick();
    expect_at(0, "shoot_hold", 2'b11, 4'b0000, 1'b0, 3'b001);
    wait_until(b + 1000);
    en = 1'b0; clr = 1'b1;
    expect_at(1, "clr_early", 2'b11, 4'b0000, 1'b0, 3'b001);
    tick();
    clr = 1'b0;
    wait_until(b + 2000);
    clr = 1'b1;
    expect_at(1, "clr_bound", 2'b11, 4'b0000, 1'b0, 3'b001);
    tick();
    en = 1'b1;
    expect_at(1, "clr_with_en", 2'b11, 4'b0000, 1'b0, 3'b001);
    tick();
    en = 1'b0;
    expect_at(1, "clr_ok", 2'b00, 4'b0000, 1'b0, 3'b000);
    tick();
    clr = 1'b0;
    tick();

    // over-limit glitches and boundaries: no fault
    start_run(4'b0001);
    iC = 14'(-6001); repeat (3) tick();
    iC = '0;         tick();
    iC = 14'(-6001); repeat (3) tick();
    iC = '0;         repeat (2) tick();
    expect_at(0, "oc_glitch", 2'b10, 4'b0001, 1'b1, 3'b000);
    iC = 14'(-6000); vC = 14'(-7000); repeat (6) tick();
    iC = 14'(6000);  vC = 14'(7000);  repeat (6) tick();
    expect_at(0, "limit_equal", 2'b10, 4'b0001, 1'b1, 3'b000);
    iC = '0; vC = '0;
    tick();

    // persistent over-current at full negative scale
    iC = 14'h2000;
    expect_at(3, "oc_3", 2'b10, 4'b0001, 1'b1, 3'b000);
    expect_at(4, "oc_trip", 2'b11, 4'b0000, 1'b0, 3'b010);
    repeat (4) tick();
    iC = '0;
    tick();
    expect_at(0, "oc_sticky", 2'b11, 4'b0000, 1'b0, 3'b010);
    clear_fault();

    // simultaneous over-current and over-voltage
    start_run(4'b0010);
    iC = 14'h2000; vC = 14'(7001);
    expect_at(4, "ocov_trip", 2'b11, 4'b0000, 1'b0, 3'b110);
    repeat (4) tick();
    iC = '0; vC = '0;
    clear_fault();

    // async reset pulse mid-RUN
    start_run(4'b1000);
    repeat (3) tick();
    expect_at(0, "async_rst", 2'b00, 4'b0000, 1'b0, 3'b000);
    #2 rst = 1'b1;
    en = 1'b0;
    #4 rst = 1'b0;
    repeat (5) tick();
    expect_at(0, "rst_idle", 2'b00, 4'b0000, 1'b0, 3'b000);
    tick();
    start_run(4'b1000);
    repeat (2) tick();

    for (int i = 0; i < 20 && sbq.size() > 0; i++) tick();
    if (sbq.size() > 0) begin
      $display("FAIL drain pending=%0d want 0", sbq.size());
      failures += sbq.size();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
